psg_frame_player: RTL and testbench
===================================

// Module: psg_frame_player
// PURPOSE
//  Autonomous register-dump player for the TurboSound pair. On each frame tick it fetches 14 register
//  bytes per chip from memory and replays them as PSG OUT cycles (chip select, register select, data).
//  It sits between the CPU I/O bus and the TurboSound port and arbitrates it: the CPU always wins.
// PARAMETERS
//  CHIPS  2   chips per frame (1 or 2); chip k selected by writing 8'hFF-k to 0xFFFD
//  FRAMES 256 frames in the dump; the frame pointer wraps to base after the last one
//  HOLD   2   cycles psg_iorq/psg_wr are held low per player OUT (>=1)
//  AW     16  memory address width
// PORTS
//  clock     in  1   system clock
//  reset     in  1   synchronous, active-high
//  enable    in  1   1 = play; 0 = stop after the current OUT, clears frame index and overrun
//  tick      in  1   one-cycle frame strobe (50 Hz)
//  base      in  AW  dump start address, sampled on the 0->1 edge of enable
//  mem_req   out 1   byte read request, held with mem_addr until mem_ack
//  mem_addr  out AW  byte address
//  mem_ack   in  1   one-cycle acknowledge; mem_data valid in the same cycle
//  mem_data  in  8   read data
//  cpu_iorq  in  1   CPU I/O strobe, active low (likewise cpu_wr, cpu_rd)
//  cpu_wr    in  1
//  cpu_rd    in  1
//  cpu_a     in  16  CPU address
//  cpu_d     in  8   CPU write data
//  psg_iorq  out 1   to TurboSound, active low (likewise psg_wr, psg_rd)
//  psg_wr    out 1
//  psg_rd    out 1
//  psg_a     out 16  to TurboSound address
//  psg_d     out 8   to TurboSound data
//  busy      out 1   frame in progress
//  overrun   out 1   sticky: tick arrived while busy
// BEHAVIOUR
//  Reset: FSM=IDLE; mem_req=0; psg_iorq=psg_wr=psg_rd=1; psg_a=0; psg_d=0; busy=0; overrun=0;
//   frame index=0; dirty=1.
//  CPU PSG access: cpu_iorq=0 and cpu_a[15]=1 and cpu_a[1]=0.
//   - While it lasts, psg_* = cpu_* combinationally (zero latency) and the player is frozen.
//   - Any player strobe in progress is aborted and the OUT retried from SELC; dirty is set.
//  Outside CPU accesses, psg_* come from the player. A player OUT (address A, data D) is:
//   - 1 setup cycle (iorq=wr=1, a/d driven), then HOLD strobe cycles (iorq=wr=0), then 1 idle cycle.
//   - psg_rd is always 1.
//  FSM:
//   - IDLE: tick & enable -> FETCH; byte=0, chip=0, busy=1.
//   - FETCH: mem_req=1, mem_addr=base+frame*14*CHIPS+chip*14+byte; on mem_ack latch data -> SELC.
//   - SELC: if dirty or byte==0: OUT(0xFFFD, 8'hFF-chip); dirty=0. -> SELR.
//   - SELR: OUT(0xFFFD, byte) -> WDAT. Skip SELR and WDAT when byte==13 and data==8'hFF
//     (envelope shape not retriggered).
//   - WDAT: OUT(0xBFFD, data) -> NEXT.
//   - NEXT: byte 13 -> byte=0, chip+1; chip CHIPS-1 -> frame+1 (mod FRAMES), busy=0, IDLE; else FETCH.
//  tick while busy: overrun<=1; tick dropped. tick in IDLE with enable=0: ignored.
//  enable 1->0 mid-frame: finish the current OUT (no truncated strobe), drop mem_req, then:
//   - -> IDLE, busy=0, frame=0, overrun=0.
//  reset mid-OUT: psg_iorq/psg_wr return to 1 on the next edge.
//  Address arithmetic mod 2^AW.
// TESTING
//  1. CHIPS=2, HOLD=2, base=0x4000, enable, one tick, zero-wait memory:
//     -> 58 OUTs, each a 4-cycle OUT as in BEHAVIOUR (two chip selects, 28 reg/data pairs);
//     -> mem addresses 0x4000..0x401B; busy low after.
//  2. Frame with R13=8'hFF -> no 0xFFFD write of 8'h0D and no data write for R13; R13=8'h0E -> written.
//  3. Second tick while busy -> overrun=1, exactly one frame played; enable 0 -> overrun=0.
//  4. CPU OUT 0xFFFD,7 during a player strobe:
//     -> cpu passes through same cycle; player strobe aborted;
//     -> player resumes with chip select 8'hFF/8'hFE then register select.
//  5. FRAMES=2: three ticks -> third frame reads base again (wrap); mem_ack delayed 5 cycles -> mem_req held, no OUT issued.
//  6. Assert reset during WDAT strobe -> next cycle psg_iorq=1, busy=0, mem_req=0.

Source files
------------

// File: rtl/psg_frame_player.sv
`default_nettype none
// ============================================================================
//  Module   : psg_frame_player
//  Purpose  : Replays a TurboSound register dump, one frame per tick.
//             Fetches 14 register bytes per chip from memory and issues
//             them as PSG OUT cycles. Arbitrates the PSG port, and the CPU
//             always wins.
//  Revision : 1.0  initial release
// ============================================================================
module psg_frame_player #(
    parameter int CHIPS  = 2,
    parameter int FRAMES = 256,
    parameter int HOLD   = 2,
    parameter int AW     = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          tick,
    input  logic [AW-1:0] base,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    input  logic          cpu_iorq,
    input  logic          cpu_wr,
    input  logic          cpu_rd,
    input  logic [15:0]   cpu_a,
    input  logic [7:0]    cpu_d,
    output logic          psg_iorq,
    output logic          psg_wr,
    output logic          psg_rd,
    output logic [15:0]   psg_a,
    output logic [7:0]    psg_d,
    output logic          busy,
    output logic          overrun
);

    localparam int FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CW          = (CHIPS > 1) ? $clog2(CHIPS) : 1;
    localparam int PW          = $clog2(HOLD + 2);
    localparam int c_FRAME_BYTES = 14 * CHIPS;
    // OUT phase: 0 = setup, 1..HOLD = strobe, HOLD+1 = idle
    localparam logic [PW-1:0] c_PH_LAST = PW'(HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SELC  = 3'd2,
        S_SELR  = 3'd3,
        S_WDAT  = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [PW-1:0]   r_ph;
    logic [3:0]      r_byte;
    logic [CW-1:0]   r_chip;
    logic [FW-1:0]   r_frame;
    logic [7:0]      r_data;
    logic [AW-1:0]   r_base;
    logic            r_en_d;
    logic            r_dirty;
    logic            r_busy;
    logic            r_overrun;

    logic            w_cpu;
    logic            w_in_out;
    logic            w_need_cs;
    logic            w_do_out;
    logic            w_out_end;
    logic            w_skip;
    logic            w_mid_strobe;
    logic            w_stop;
    logic            w_abort;
    logic            w_last_byte;
    logic            w_last_chip;
    logic            w_pstb;
    logic [15:0]     w_pa;
    logic [7:0]      w_pd;
    logic [AW-1:0]   w_off;

    assign w_cpu        = !cpu_iorq && cpu_a[15] && !cpu_a[1];
    assign w_in_out     = (r_state == S_SELC) || (r_state == S_SELR) || (r_state == S_WDAT);
    // Chip select is re-sent at the start of each chip and after any CPU
    // access, since the CPU may have left another chip or register selected.
    assign w_need_cs    = r_dirty || (r_byte == 4'd0);
    assign w_do_out     = ((r_state == S_SELC) && w_need_cs) ||
                          (r_state == S_SELR) || (r_state == S_WDAT);
    assign w_out_end    = w_do_out && (r_ph == c_PH_LAST);
    // Writing R13 retriggers the envelope, so 0xFF in the dump means "leave it"
    assign w_skip       = (r_byte == 4'd13) && (r_data == 8'hFF);
    assign w_mid_strobe = w_in_out && (r_ph != '0) && (r_ph != c_PH_LAST);
    // A strobe once started is always completed before stopping
    assign w_stop       = !enable && !w_mid_strobe;
    assign w_abort      = w_cpu && w_in_out;
    assign w_last_byte  = (r_byte == 4'd13);
    assign w_last_chip  = (r_chip == CW'(CHIPS - 1));

    assign w_off    = AW'(r_frame) * AW'(c_FRAME_BYTES) + AW'(r_chip) * AW'(14) + AW'(r_byte);
    assign mem_addr = r_base + w_off;
    assign mem_req  = (r_state == S_FETCH) && enable;

    // CPU accesses pass straight through with no register in the path
    assign psg_iorq = w_cpu ? cpu_iorq : !w_pstb;
    assign psg_wr   = w_cpu ? cpu_wr   : !w_pstb;
    assign psg_rd   = w_cpu ? cpu_rd   : 1'b1;
    assign psg_a    = w_cpu ? cpu_a    : w_pa;
    assign psg_d    = w_cpu ? cpu_d    : w_pd;

    assign busy     = r_busy;
    assign overrun  = r_overrun;

    // Next-state selection and player-side bus drive
    always_comb begin
        w_state_nx = r_state;
        w_pa       = 16'h0000;
        w_pd       = 8'h00;
        w_pstb     = w_do_out && (r_ph != '0) && (r_ph != c_PH_LAST);

        case (r_state)
            S_IDLE: begin
                if (enable && tick) w_state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) w_state_nx = S_SELC;
            end
            S_SELC: begin
                w_pa = 16'hFFFD;
                w_pd = 8'hFF - 8'(r_chip);
                if (!w_need_cs || w_out_end) w_state_nx = w_skip ? S_NEXT : S_SELR;
            end
            S_SELR: begin
                w_pa = 16'hFFFD;
                w_pd = {4'h0, r_byte};
                if (w_out_end) w_state_nx = S_WDAT;
            end
            S_WDAT: begin
                w_pa = 16'hBFFD;
                w_pd = r_data;
                if (w_out_end) w_state_nx = S_NEXT;
            end
            S_NEXT: begin
                w_state_nx = (w_last_byte && w_last_chip) ? S_IDLE : S_FETCH;
            end
            default: w_state_nx = S_IDLE;
        endcase

        // CPU takeover restarts the interrupted OUT from the chip select
        if (w_abort)     w_state_nx = S_SELC;
        else if (w_stop) w_state_nx = S_IDLE;
    end

    // State register plus frame/chip/byte bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ph      <= '0;
            r_byte    <= 4'd0;
            r_chip    <= '0;
            r_frame   <= '0;
            r_data    <= 8'h00;
            r_base    <= '0;
            r_en_d    <= 1'b0;
            r_dirty   <= 1'b1;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_en_d  <= enable;
            if (enable && !r_en_d) r_base <= base;

            if (w_abort || w_stop)        r_ph <= '0;
            else if (w_do_out)            r_ph <= (r_ph == c_PH_LAST) ? '0 : r_ph + 1'b1;
            else                          r_ph <= '0;

            if ((r_state == S_IDLE) && enable && tick) begin
                r_byte <= 4'd0;
                r_chip <= '0;
                r_busy <= 1'b1;
            end

            if (tick && r_busy) r_overrun <= 1'b1;

            if ((r_state == S_FETCH) && mem_ack) r_data <= mem_data;

            if ((r_state == S_SELC) && w_out_end) r_dirty <= 1'b0;

            if (r_state == S_NEXT) begin
                if (w_last_byte) begin
                    r_byte <= 4'd0;
                    if (w_last_chip) begin
                        r_chip  <= '0;
                        r_frame <= (r_frame == FW'(FRAMES - 1)) ? '0 : r_frame + 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_chip <= r_chip + 1'b1;
                    end
                end else begin
                    r_byte <= r_byte + 4'd1;
                end
            end

            if (w_cpu) r_dirty <= 1'b1;

            if (w_stop && !w_abort) begin
                r_busy    <= 1'b0;
                r_frame   <= '0;
                r_overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psg_frame_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psg_frame_player
//  Purpose  : Scoreboard bench for psg_frame_player. Expected PSG OUTs and
//             memory addresses are queued as stimulus is issued; a monitor
//             pops and compares them as the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psg_frame_player;

    localparam int CHIPS  = 2;
    localparam int FRAMES = 2;
    localparam int HOLD   = 2;
    localparam int AW     = 16;

    logic          clock = 1'b0;
    logic          reset, enable, tick;
    logic [15:0]   base;
    logic          mem_req, mem_ack;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_data;
    logic          cpu_iorq, cpu_wr, cpu_rd;
    logic [15:0]   cpu_a;
    logic [7:0]    cpu_d;
    logic          psg_iorq, psg_wr, psg_rd;
    logic [15:0]   psg_a;
    logic [7:0]    psg_d;
    logic          busy, overrun;

    always #5 clock = ~clock;

    psg_frame_player #(.CHIPS(CHIPS), .FRAMES(FRAMES), .HOLD(HOLD), .AW(AW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .tick(tick), .base(base),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .cpu_iorq(cpu_iorq), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .psg_iorq(psg_iorq), .psg_wr(psg_wr), .psg_rd(psg_rd), .psg_a(psg_a), .psg_d(psg_d),
        .busy(busy), .overrun(overrun)
    );

    // Memory: 256-byte window, acknowledge after 'lat' wait cycles
    logic [7:0] mem [256];
    int         lat = 0;
    int         wcnt = 0;
    assign mem_ack  = mem_req && (wcnt >= lat);
    assign mem_data = mem[mem_addr[7:0]];
    always @(posedge clock) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          len;   // 0 = strobe length not checked
    } out_t;

    out_t        exp_q[$];
    out_t        tmp_q[$];
    logic [15:0] addr_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_outs = 0;
    int          strobe_starts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected OUTs and fetch addresses for one frame of the dump
    task automatic build_frame(input int fr);
        tmp_q.delete();
        for (int c = 0; c < CHIPS; c++) begin
            for (int b = 0; b < 14; b++) begin
                logic [15:0] ad;
                logic [7:0]  dv;
                out_t        e;
                ad = 16'h4000 + 16'(fr * 28 + c * 14 + b);
                addr_q.push_back(ad);
                dv = mem[ad[7:0]];
                if (b == 0) begin
                    e.a = 16'hFFFD; e.d = 8'hFF - 8'(c); e.len = HOLD; tmp_q.push_back(e);
                end
                if (!(b == 13 && dv == 8'hFF)) begin
                    e.a = 16'hFFFD; e.d = 8'(b); e.len = HOLD; tmp_q.push_back(e);
                    e.a = 16'hBFFD; e.d = dv;    e.len = HOLD; tmp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic push_all();
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    endtask

    task automatic push_out(input logic [15:0] a, input logic [7:0] d, input int len);
        out_t e;
        e.a = a; e.d = d; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic pulse_tick();
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
    endtask

    task automatic set_enable(input logic v);
        @(posedge clock); #1 enable = v;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        repeat (2) @(posedge clock);
        k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(posedge clock);
            k++;
        end
        #1 check(name, busy, 1'b0);
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic check_drained(input string name);
        check({name, "_outq"}, exp_q.size(), 0);
        check({name, "_addrq"}, addr_q.size(), 0);
    endtask

    // Monitor: one entry per completed strobe, one per memory acknowledge
    initial begin : mon
        logic        stb;
        logic        prev_stb;
        int          cur_len;
        logic [15:0] last_a;
        logic [7:0]  last_d;
        out_t        e;
        prev_stb = 1'b0;
        cur_len  = 0;
        last_a   = 16'h0;
        last_d   = 8'h0;
        forever begin
            @(negedge clock);
            stb = (psg_iorq === 1'b0) && (psg_wr === 1'b0);
            if (stb) begin
                if (!prev_stb) begin
                    strobe_starts++;
                    cur_len = 0;
                end
                cur_len++;
                last_a = psg_a;
                last_d = psg_d;
            end else if (prev_stb) begin
                n_outs++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL out_unexpected: got a=0x%h d=0x%h, expected no OUT", last_a, last_d);
                end else begin
                    e = exp_q.pop_front();
                    check("out_addr", last_a, e.a);
                    check("out_data", last_d, e.d);
                    if (e.len != 0) check("out_len", cur_len, e.len);
                end
            end
            prev_stb = stb;
            if (mem_ack === 1'b1) begin
                if (addr_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL mem_unexpected: got addr=0x%h, expected no fetch", mem_addr);
                end else begin
                    check("mem_addr", mem_addr, addr_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int s0;
        out_t t[$];
        reset = 1'b1; enable = 1'b0; tick = 1'b0; base = 16'h4000;
        cpu_iorq = 1'b1; cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_a = 16'h0; cpu_d = 8'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[13] = 8'h0D;
        mem[27] = 8'h0E;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_psg_iorq", psg_iorq, 1'b1);
        check("rst_psg_wr", psg_wr, 1'b1);
        check("rst_psg_rd", psg_rd, 1'b1);
        check("rst_psg_a", psg_a, 16'h0000);
        check("rst_psg_d", psg_d, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        @(posedge clock); #1 reset = 1'b0;

        // Full frame, zero-wait memory
        set_enable(1'b1);
        build_frame(0); push_all();
        n0 = n_outs;
        pulse_tick();
        wait_idle("t1_done");
        check("t1_out_count", n_outs - n0, 58);
        check_drained("t1");

        // R13 = 0xFF on chip 0 is skipped, R13 = 0x0E on chip 1 is written
        mem[41] = 8'hFF;
        mem[55] = 8'h0E;
        build_frame(1); push_all();
        n0 = n_outs;
        pulse_tick();
        wait_idle("t2_done");
        check("t2_out_count", n_outs - n0, 56);
        check_drained("t2");

        // Tick while busy: overrun, only one frame played; disable clears it
        build_frame(0); push_all();
        n0 = n_outs;
        pulse_tick();
        repeat (20) @(posedge clock);
        pulse_tick();
        check("t3_overrun", overrun, 1'b1);
        wait_idle("t3_done");
        repeat (100) @(posedge clock);
        #1;
        check("t3_still_idle", busy, 1'b0);
        check("t3_out_count", n_outs - n0, 58);
        check_drained("t3");
        set_enable(1'b0);
        check("t3_overrun_clr", overrun, 1'b0);

        // CPU OUT during the 5th player strobe (WDAT of R1)
        set_enable(1'b1);
        build_frame(0);
        t = tmp_q;
        for (int i = 0; i < 4; i++) exp_q.push_back(t[i]);
        push_out(16'hFFFD, 8'h07, 0);
        push_out(16'hFFFD, 8'hFF, HOLD);
        exp_q.push_back(t[3]);
        exp_q.push_back(t[4]);
        for (int i = 5; i < t.size(); i++) exp_q.push_back(t[i]);
        s0 = strobe_starts;
        pulse_tick();
        for (int k = 0; k < 500; k++) begin
            @(negedge clock); #1;
            if (strobe_starts >= s0 + 5) break;
        end
        check("t4_reached", strobe_starts - s0, 5);
        cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_a = 16'hFFFD; cpu_d = 8'h07;
        #1;
        check("t4_pass_a", psg_a, 16'hFFFD);
        check("t4_pass_d", psg_d, 8'h07);
        check("t4_pass_iorq", psg_iorq, 1'b0);
        check("t4_pass_wr", psg_wr, 1'b0);
        repeat (2) @(posedge clock);
        #1 cpu_iorq = 1'b1; cpu_wr = 1'b1; cpu_a = 16'h0000; cpu_d = 8'h00;
        #1;
        check("t4_resume_iorq", psg_iorq, 1'b1);
        check("t4_resume_a", psg_a, 16'hFFFD);
        check("t4_resume_d", psg_d, 8'hFF);
        wait_idle("t4_done");
        check_drained("t4");

        // FRAMES=2 wrap: frames 0, 1, 0; third frame with 5-cycle memory wait
        set_enable(1'b0);
        set_enable(1'b1);
        build_frame(0); push_all();
        pulse_tick();
        wait_idle("t5_f0");
        build_frame(1); push_all();
        pulse_tick();
        wait_idle("t5_f1");
        lat = 5;
        build_frame(0); push_all();
        pulse_tick();
        for (int k = 0; k < 5; k++) begin
            check("t5_req_held", mem_req, 1'b1);
            check("t5_no_ack", mem_ack, 1'b0);
            check("t5_no_out", psg_iorq, 1'b1);
            check("t5_wrap_addr", mem_addr, 16'h4000);
            @(posedge clock); #1;
        end
        wait_idle("t5_f2");
        lat = 0;
        check_drained("t5");

        // Disable during a strobe: the strobe completes, then the player stops
        set_enable(1'b0);
        set_enable(1'b1);
        push_out(16'hFFFD, 8'hFF, HOLD);
        addr_q.push_back(16'h4000);
        n0 = n_outs;
        s0 = strobe_starts;
        pulse_tick();
        for (int k = 0; k < 200; k++) begin
            @(negedge clock); #1;
            if (strobe_starts >= s0 + 1) break;
        end
        enable = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("t7_busy", busy, 1'b0);
        check("t7_mem_req", mem_req, 1'b0);
        check("t7_out_count", n_outs - n0, 1);
        check_drained("t7");

        // Reset during the WDAT strobe of R0
        set_enable(1'b1);
        push_out(16'hFFFD, 8'hFF, HOLD);
        push_out(16'hFFFD, 8'h00, HOLD);
        push_out(16'hBFFD, mem[0], 1);
        addr_q.push_back(16'h4000);
        pulse_tick();
        for (int k = 0; k < 200; k++) begin
            @(negedge clock); #1;
            if (psg_iorq === 1'b0 && psg_a === 16'hBFFD) break;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        check("t6_iorq", psg_iorq, 1'b1);
        check("t6_wr", psg_wr, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_mem_req", mem_req, 1'b0);
        enable = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check_drained("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
